// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU selects, FSM states, control vector.
// The S_TRAP state exists only when MCTRL_ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_OR    = 3'b011,
    ALU_AND   = 3'b100
  } aluop_t;

  typedef enum logic [2:0] {
    SRCB_B        = 3'b000,
    SRCB_FOUR     = 3'b001,
    SRCB_SIGNIMM  = 3'b010,
    SRCB_SIMM_SH2 = 3'b011,
    SRCB_ZEROIMM  = 3'b100
  } alusrcb_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_IMMEX,
    S_IMMWB,
    S_BREX,
`ifdef MCTRL_ILLEGAL_TRAP_EN
    S_JEX,
    S_TRAP
`else
    S_JEX
`endif
  } statetype_t;

  // irwrite and pcwrite here are ungated; the top applies the fetch mem_ready gate.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic [1:0] pcsrc;
    logic       alusrca;
    alusrcb_t   alusrcb;
    aluop_t     aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       half;
    logic       b;
    logic       lbu;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ORI, OP_ANDI, OP_J, OP_LH, OP_LB, OP_LBU: is_legal_op = 1'b1;
      default:                                     is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Unified-memory handshake between the multicycle controller (master) and the memory (slave).
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic iord;
  logic memwrite;

  modport master (output mem_req, output iord, output memwrite, input mem_ready);
  modport slave  (input mem_req, input iord, input memwrite, output mem_ready);
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode: (state, op_q) -> control vector. op is looked at only in S_DECODE
// to flag an illegal opcode, since op_q is not loaded until the end of that cycle.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  statetype_t  state,
  input  logic [5:0]  op,
  input  logic [5:0]  op_q,
  output ctrl_t       ctrl
);

  logic is_lh, is_lb, is_lbu;

  assign is_lh  = (op_q == OP_LH);
  assign is_lb  = (op_q == OP_LB);
  assign is_lbu = (op_q == OP_LBU);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_SIMM_SH2;
        ctrl.aluop   = ALU_ADD;
        ctrl.illegal = ~is_legal_op(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_SIGNIMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.half    = is_lh | is_lb;
        ctrl.b       = is_lb;
        ctrl.lbu     = is_lbu;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.half     = is_lh | is_lb;
        ctrl.b        = is_lb;
        ctrl.lbu      = is_lbu;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        case (op_q)
          OP_ORI:  begin ctrl.alusrcb = SRCB_ZEROIMM; ctrl.aluop = ALU_OR;  end
          OP_ANDI: begin ctrl.alusrcb = SRCB_ZEROIMM; ctrl.aluop = ALU_AND; end
          default: begin ctrl.alusrcb = SRCB_SIGNIMM; ctrl.aluop = ALU_ADD; end
        endcase
      end
      S_IMMWB: ctrl.regwrite = 1'b1;
      S_BREX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
        ctrl.ne      = (op_q == OP_BNE);
      end
      S_JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
`ifdef MCTRL_ILLEGAL_TRAP_EN
      S_TRAP: ctrl.illegal = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, latched opcode and next-state logic.
// Define MCTRL_ILLEGAL_TRAP_EN to make an illegal opcode lock the FSM in S_TRAP until reset.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_ctrl_if.master        bus,
  input  logic [5:0]                    op,
  input  logic                          zero,
  output logic                          irwrite,
  output logic                          pc_en,
  output logic [1:0]                    pcsrc,
  output logic                          alusrca,
  output logic [2:0]                    alusrcb,
  output logic [2:0]                    aluop,
  output logic                          regdst,
  output logic                          memtoreg,
  output logic                          regwrite,
  output logic                          half,
  output logic                          b,
  output logic                          lbu,
  output logic                          illegal
);

  statetype_t state, state_n;
  logic [5:0] op_q;
  ctrl_t      ctrl;
  logic       fetch_gate;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) op_q <= op;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = S_FETCH;
      S_FETCH:   if (bus.mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:                           state_n = S_RTYPEEX;
          OP_BEQ, OP_BNE:                     state_n = S_BREX;
          OP_ADDI, OP_ORI, OP_ANDI:           state_n = S_IMMEX;
          OP_J:                               state_n = S_JEX;
`ifdef MCTRL_ILLEGAL_TRAP_EN
          default:                            state_n = S_TRAP;
`else
          default:                            state_n = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_n = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.mem_ready) state_n = S_MEMWB;
      S_MEMWB:   state_n = S_FETCH;
      S_MEMWR:   if (bus.mem_ready) state_n = S_FETCH;
      S_RTYPEEX: state_n = S_RTYPEWB;
      S_RTYPEWB: state_n = S_FETCH;
      S_IMMEX:   state_n = S_IMMWB;
      S_IMMWB:   state_n = S_FETCH;
      S_BREX:    state_n = S_FETCH;
      S_JEX:     state_n = S_FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      S_TRAP:    state_n = S_TRAP;
`endif
      default:   state_n = S_IDLE;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state (state),
    .op    (op),
    .op_q  (op_q),
    .ctrl  (ctrl)
  );

  // Only the fetch state raises irwrite, so it doubles as the marker for mem_ready gating.
  assign fetch_gate   = ctrl.irwrite ? bus.mem_ready : 1'b1;

  assign bus.mem_req  = ctrl.mem_req;
  assign bus.iord     = ctrl.iord;
  assign bus.memwrite = ctrl.memwrite;
  assign irwrite      = ctrl.irwrite & bus.mem_ready;
  assign pc_en        = (ctrl.pcwrite & fetch_gate) | (ctrl.branch & (zero ^ ctrl.ne));
  assign pcsrc        = ctrl.pcsrc;
  assign alusrca      = ctrl.alusrca;
  assign alusrcb      = ctrl.alusrcb;
  assign aluop        = ctrl.aluop;
  assign regdst       = ctrl.regdst;
  assign memtoreg     = ctrl.memtoreg;
  assign regwrite     = ctrl.regwrite;
  assign half         = ctrl.half;
  assign b            = ctrl.b;
  assign lbu          = ctrl.lbu;
  assign illegal      = ctrl.illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed instruction sequences push expected
// control vectors; a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_multicycle_ctrl;

  typedef struct {
    logic [20:0] v;
    string       name;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       irwrite, pc_en, alusrca, regdst, memtoreg, regwrite, half, b, lbu, illegal;
  logic [1:0] pcsrc;
  logic [2:0] alusrcb, aluop;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .op       (op),
    .zero     (zero),
    .irwrite  (irwrite),
    .pc_en    (pc_en),
    .pcsrc    (pcsrc),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .half     (half),
    .b        (b),
    .lbu      (lbu),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [20:0] act;

  // {mem_req, iord, memwrite, irwrite, pc_en, pcsrc, alusrca, alusrcb, aluop,
  //  regdst, memtoreg, regwrite, half, b, lbu, illegal}
  function automatic logic [20:0] mk(input logic mreq, input logic io, input logic mw,
                                     input logic irw, input logic pce, input logic [1:0] pcs,
                                     input logic asa, input logic [2:0] asb, input logic [2:0] aop,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic h, input logic bb, input logic lb, input logic ill);
    return {mreq, io, mw, irw, pce, pcs, asa, asb, aop, rd, m2r, rw, h, bb, lb, ill};
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      act = {bus.mem_req, bus.iord, bus.memwrite, irwrite, pc_en, pcsrc, alusrca, alusrcb,
             aluop, regdst, memtoreg, regwrite, half, b, lbu, illegal};
      n_cmp++;
      if (act !== cur.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.v);
      end
    end
  end

  task automatic step(input string nm, input logic rst_v, input logic [5:0] o,
                      input logic z, input logic rdy, input logic [20:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    reset         = rst_v;
    op            = o;
    zero          = z;
    bus.mem_ready = rdy;
    x.v           = e;
    x.name        = nm;
    sb.push_back(x);
  endtask

  logic [20:0] ZERO, F_RDY, F_STL, DEC, DEC_ILL, MADR, MWR, REX, RWB, IWB, JX, TRAP;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ZERO    = '0;
    F_RDY   = mk(1,0,0,1,1,2'b00,0,3'b001,3'b000,0,0,0,0,0,0,0);
    F_STL   = mk(1,0,0,0,0,2'b00,0,3'b001,3'b000,0,0,0,0,0,0,0);
    DEC     = mk(0,0,0,0,0,2'b00,0,3'b011,3'b000,0,0,0,0,0,0,0);
    DEC_ILL = mk(0,0,0,0,0,2'b00,0,3'b011,3'b000,0,0,0,0,0,0,1);
    MADR    = mk(0,0,0,0,0,2'b00,1,3'b010,3'b000,0,0,0,0,0,0,0);
    MWR     = mk(1,1,1,0,0,2'b00,0,3'b000,3'b000,0,0,0,0,0,0,0);
    REX     = mk(0,0,0,0,0,2'b00,1,3'b000,3'b010,0,0,0,0,0,0,0);
    RWB     = mk(0,0,0,0,0,2'b00,0,3'b000,3'b000,1,0,1,0,0,0,0);
    IWB     = mk(0,0,0,0,0,2'b00,0,3'b000,3'b000,0,0,1,0,0,0,0);
    JX      = mk(0,0,0,0,1,2'b10,0,3'b000,3'b000,0,0,0,0,0,0,0);
    TRAP    = mk(0,0,0,0,0,2'b00,0,3'b000,3'b000,0,0,0,0,0,0,1);

    reset = 1'b0; op = '0; zero = 1'b0; bus.mem_ready = 1'b0;

    step("rst_hold",  0, 6'h00, 0, 1, ZERO);
    step("idle",      1, 6'h00, 0, 1, ZERO);

    // LW, memory always ready: 5 cycles, regwrite only in the last
    step("lw_fetch",  1, 6'b100011, 0, 1, F_RDY);
    step("lw_dec",    1, 6'b100011, 0, 1, DEC);
    step("lw_madr",   1, 6'b100011, 0, 1, MADR);
    step("lw_mrd",    1, 6'b100011, 0, 1, mk(1,1,0,0,0,2'b00,0,3'b000,3'b000,0,0,0,0,0,0,0));
    step("lw_mwb",    1, 6'b100011, 0, 1, mk(0,0,0,0,0,2'b00,0,3'b000,3'b000,0,1,1,0,0,0,0));

    // LB with a fetch stall and a 3-cycle read stall
    step("lb_fstall", 1, 6'b100000, 0, 0, F_STL);
    step("lb_fetch",  1, 6'b100000, 0, 1, F_RDY);
    step("lb_dec",    1, 6'b100000, 0, 1, DEC);
    step("lb_madr",   1, 6'b100000, 0, 1, MADR);
    for (int i = 0; i < 3; i++)
      step("lb_mrd_stall", 1, 6'b100000, 0, 0, mk(1,1,0,0,0,2'b00,0,3'b000,3'b000,0,0,0,1,1,0,0));
    step("lb_mrd",    1, 6'b100000, 0, 1, mk(1,1,0,0,0,2'b00,0,3'b000,3'b000,0,0,0,1,1,0,0));
    step("lb_mwb",    1, 6'b100000, 0, 1, mk(0,0,0,0,0,2'b00,0,3'b000,3'b000,0,1,1,1,1,0,0));

    // LH and LBU width bits
    step("lh_fetch",  1, 6'b100001, 0, 1, F_RDY);
    step("lh_dec",    1, 6'b100001, 0, 1, DEC);
    step("lh_madr",   1, 6'b100001, 0, 1, MADR);
    step("lh_mrd",    1, 6'b100001, 0, 1, mk(1,1,0,0,0,2'b00,0,3'b000,3'b000,0,0,0,1,0,0,0));
    step("lh_mwb",    1, 6'b100001, 0, 1, mk(0,0,0,0,0,2'b00,0,3'b000,3'b000,0,1,1,1,0,0,0));
    step("lbu_fetch", 1, 6'b100100, 0, 1, F_RDY);
    step("lbu_dec",   1, 6'b100100, 0, 1, DEC);
    step("lbu_madr",  1, 6'b100100, 0, 1, MADR);
    step("lbu_mrd",   1, 6'b100100, 0, 1, mk(1,1,0,0,0,2'b00,0,3'b000,3'b000,0,0,0,0,0,1,0));
    step("lbu_mwb",   1, 6'b100100, 0, 1, mk(0,0,0,0,0,2'b00,0,3'b000,3'b000,0,1,1,0,0,1,0));

    // Branches: pc_en follows zero ^ ne in S_BREX
    step("bne0_fetch", 1, 6'b000101, 0, 1, F_RDY);
    step("bne0_dec",   1, 6'b000101, 0, 1, DEC);
    step("bne0_brex",  1, 6'b000101, 0, 1, mk(0,0,0,0,1,2'b01,1,3'b000,3'b001,0,0,0,0,0,0,0));
    step("bne1_fetch", 1, 6'b000101, 1, 1, F_RDY);
    step("bne1_dec",   1, 6'b000101, 1, 1, DEC);
    step("bne1_brex",  1, 6'b000101, 1, 1, mk(0,0,0,0,0,2'b01,1,3'b000,3'b001,0,0,0,0,0,0,0));
    step("beq1_fetch", 1, 6'b000100, 1, 1, F_RDY);
    step("beq1_dec",   1, 6'b000100, 1, 1, DEC);
    step("beq1_brex",  1, 6'b000100, 1, 1, mk(0,0,0,0,1,2'b01,1,3'b000,3'b001,0,0,0,0,0,0,0));

    // Immediate ALU ops
    step("andi_fetch", 1, 6'b001100, 0, 1, F_RDY);
    step("andi_dec",   1, 6'b001100, 0, 1, DEC);
    step("andi_ex",    1, 6'b001100, 0, 1, mk(0,0,0,0,0,2'b00,1,3'b100,3'b100,0,0,0,0,0,0,0));
    step("andi_wb",    1, 6'b001100, 0, 1, IWB);
    step("ori_fetch",  1, 6'b001101, 0, 1, F_RDY);
    step("ori_dec",    1, 6'b001101, 0, 1, DEC);
    step("ori_ex",     1, 6'b001101, 0, 1, mk(0,0,0,0,0,2'b00,1,3'b100,3'b011,0,0,0,0,0,0,0));
    step("ori_wb",     1, 6'b001101, 0, 1, IWB);
    step("addi_fetch", 1, 6'b001000, 0, 1, F_RDY);
    step("addi_dec",   1, 6'b001000, 0, 1, DEC);
    step("addi_ex",    1, 6'b001000, 0, 1, mk(0,0,0,0,0,2'b00,1,3'b010,3'b000,0,0,0,0,0,0,0));
    step("addi_wb",    1, 6'b001000, 0, 1, IWB);

    step("rt_fetch",   1, 6'b000000, 0, 1, F_RDY);
    step("rt_dec",     1, 6'b000000, 0, 1, DEC);
    step("rt_ex",      1, 6'b000000, 0, 1, REX);
    step("rt_wb",      1, 6'b000000, 0, 1, RWB);

    step("j_fetch",    1, 6'b000010, 0, 1, F_RDY);
    step("j_dec",      1, 6'b000010, 0, 1, DEC);
    step("j_ex",       1, 6'b000010, 0, 1, JX);

    // SW with one stalled write cycle
    step("sw_fetch",   1, 6'b101011, 0, 1, F_RDY);
    step("sw_dec",     1, 6'b101011, 0, 1, DEC);
    step("sw_madr",    1, 6'b101011, 0, 1, MADR);
    step("sw_mwr_stl", 1, 6'b101011, 0, 0, MWR);
    step("sw_mwr",     1, 6'b101011, 0, 1, MWR);

    // Illegal opcode
    step("ill_fetch",  1, 6'b111111, 0, 1, F_RDY);
    step("ill_dec",    1, 6'b111111, 0, 1, DEC_ILL);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      step("ill_trap", 1, 6'b100011, 0, 1, TRAP);
`else
    step("ill_nop_fetch", 1, 6'b000000, 0, 0, F_STL);
`endif
    step("ill_rst",    0, 6'b000000, 0, 1, ZERO);
    step("ill_idle",   1, 6'b000000, 0, 1, ZERO);

    // Reset asserted mid S_MEMWR while mem_ready is low
    step("rs_fetch",   1, 6'b101011, 0, 1, F_RDY);
    step("rs_dec",     1, 6'b101011, 0, 1, DEC);
    step("rs_madr",    1, 6'b101011, 0, 1, MADR);
    step("rs_mwr",     1, 6'b101011, 0, 0, MWR);
    step("rs_abort",   0, 6'b101011, 0, 0, ZERO);
    step("rs_idle",    1, 6'b101011, 0, 0, ZERO);
    step("rs_fetch2",  1, 6'b101011, 0, 0, F_STL);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
